// File: rtl/vliw_pipe_pkg.sv
// Shared definitions for the two-slot VLIW front end: NOP encoding, controller
// states, default PC step and the stall_len encoding.
package vliw_pipe_pkg;

  localparam logic [31:0] NOP_INSTR = '0;
  localparam int unsigned PC_INC_DEF = 8;
  localparam int unsigned STALL_LEN_W = 2;

  typedef enum logic {RUN, STALL} fetch_state_t;
  typedef logic [STALL_LEN_W-1:0] stall_len_t;

  // stall_len 0 means one cycle; returns the cycles remaining after the first.
  function automatic stall_len_t stall_extra(input stall_len_t len);
    return (len == '0) ? '0 : stall_len_t'(len - 1'b1);
  endfunction

endpackage

// File: rtl/fetch_stall_ctrl_pc_reg.sv
// Program counter with next-PC mux: hold, sequential advance or redirect.
module pc_reg #(
  parameter int unsigned AW     = 32,
  parameter int unsigned PC_INC = 8
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          pc_write,
  input  logic          load_target,
  input  logic [AW-1:0] target,
  output logic [AW-1:0] pc
);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pc <= '0;
    end else if (pc_write) begin
      pc <= load_target ? target : pc + AW'(PC_INC);
    end
  end

endmodule

// File: rtl/fetch_stall_ctrl.sv
// Front-end controller: owns PC and the IF/ID bundle register, turns stall
// requests into held cycles plus ID/EX bubbles, and applies branch flushes.
module fetch_stall_ctrl
  import vliw_pipe_pkg::*;
#(
  parameter int unsigned AW     = 32,
  parameter int unsigned IW     = 32,
  parameter int unsigned PC_INC = PC_INC_DEF
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          stall_req,
  input  logic [1:0]    stall_len,
  input  logic          flush_req,
  input  logic [AW-1:0] flush_target,
  input  logic [IW-1:0] if_instr_p1,
  input  logic [IW-1:0] if_instr_p2,
  output logic [AW-1:0] pc,
  output logic [IW-1:0] id_instr_p1,
  output logic [IW-1:0] id_instr_p2,
  output logic          id_valid,
  output logic          pc_write,
  output logic          if_id_write,
  output logic          id_ex_bubble,
  output logic          stall_active,
  output logic [1:0]    stall_cnt
);

  fetch_state_t state, next_state;
  stall_len_t   next_cnt;
  stall_len_t   extra;

  assign extra        = stall_extra(stall_len);
  assign stall_active = (state == STALL);

  // Control outputs are combinational so ID/EX bubbles in the hazard cycle.
  always_comb begin
    next_state   = state;
    next_cnt     = stall_cnt;
    pc_write     = 1'b1;
    if_id_write  = 1'b1;
    id_ex_bubble = 1'b0;
    if (rst) begin
      pc_write     = 1'b0;
      if_id_write  = 1'b0;
      id_ex_bubble = 1'b1;
    end else if (flush_req) begin
      id_ex_bubble = 1'b1;
      next_state   = RUN;
      next_cnt     = '0;
    end else if (state == STALL) begin
      pc_write     = 1'b0;
      if_id_write  = 1'b0;
      id_ex_bubble = 1'b1;
      next_cnt     = stall_cnt - 2'd1;
      if (stall_cnt <= 2'd1) next_state = RUN;
    end else if (stall_req) begin
      pc_write     = 1'b0;
      if_id_write  = 1'b0;
      id_ex_bubble = 1'b1;
      next_cnt     = extra;
      next_state   = (extra != '0) ? STALL : RUN;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= RUN;
      stall_cnt <= '0;
    end else begin
      state     <= next_state;
      stall_cnt <= next_cnt;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      id_instr_p1 <= IW'(NOP_INSTR);
      id_instr_p2 <= IW'(NOP_INSTR);
      id_valid    <= 1'b0;
    end else if (if_id_write) begin
      if (flush_req) begin
        id_instr_p1 <= IW'(NOP_INSTR);
        id_instr_p2 <= IW'(NOP_INSTR);
        id_valid    <= 1'b0;
      end else begin
        id_instr_p1 <= if_instr_p1;
        id_instr_p2 <= if_instr_p2;
        id_valid    <= 1'b1;
      end
    end
  end

  pc_reg #(
    .AW     (AW),
    .PC_INC (PC_INC)
  ) u_pc_reg (
    .clk         (clk),
    .rst         (rst),
    .pc_write    (pc_write),
    .load_target (flush_req),
    .target      (flush_target),
    .pc          (pc)
  );

endmodule

// File: tb/tb_fetch_stall_ctrl.sv
// Directed bench for fetch_stall_ctrl with hand-computed expectations.
module tb_fetch_stall_ctrl;

  logic        clk = 1'b0;
  logic        rst;
  logic        stall_req;
  logic [1:0]  stall_len;
  logic        flush_req;
  logic [31:0] flush_target;
  logic [31:0] if_instr_p1, if_instr_p2;
  logic [31:0] pc;
  logic [31:0] id_instr_p1, id_instr_p2;
  logic        id_valid, pc_write, if_id_write, id_ex_bubble, stall_active;
  logic [1:0]  stall_cnt;

  int unsigned total = 0;
  int unsigned bad   = 0;

  fetch_stall_ctrl #(.AW(32), .IW(32), .PC_INC(8)) dut (
    .clk          (clk),
    .rst          (rst),
    .stall_req    (stall_req),
    .stall_len    (stall_len),
    .flush_req    (flush_req),
    .flush_target (flush_target),
    .if_instr_p1  (if_instr_p1),
    .if_instr_p2  (if_instr_p2),
    .pc           (pc),
    .id_instr_p1  (id_instr_p1),
    .id_instr_p2  (id_instr_p2),
    .id_valid     (id_valid),
    .pc_write     (pc_write),
    .if_id_write  (if_id_write),
    .id_ex_bubble (id_ex_bubble),
    .stall_active (stall_active),
    .stall_cnt    (stall_cnt)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    if (obs !== exp) begin
      bad++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Combinational control outputs: {pc_write, if_id_write, id_ex_bubble}
  task automatic check_ctl(input string tag, input logic [2:0] exp);
    check(tag, {29'd0, pc_write, if_id_write, id_ex_bubble}, {29'd0, exp});
  endtask

  initial begin
    rst = 1'b1; stall_req = 1'b0; stall_len = 2'd0; flush_req = 1'b0;
    flush_target = '0; if_instr_p1 = 32'hDEAD_0001; if_instr_p2 = 32'hDEAD_0002;
    #3;
    check("rst_pc", pc, 32'd0);
    check("rst_id_p1", id_instr_p1, 32'd0);
    check("rst_id_p2", id_instr_p2, 32'd0);
    check("rst_valid", {31'd0, id_valid}, 32'd0);
    check("rst_active", {31'd0, stall_active}, 32'd0);
    check("rst_cnt", {30'd0, stall_cnt}, 32'd0);
    check_ctl("rst_ctl", 3'b001);
    step(); step();
    rst = 1'b0;

    // Free running fetch from reset
    for (int i = 0; i < 2; i++) begin
      if_instr_p1 = 32'd1000 + 32'(i);
      if_instr_p2 = 32'd2000 + 32'(i);
      #1;
      check("run_pc", pc, 32'(8 * i));
      check_ctl("run_ctl", 3'b110);
      step();
      check("run_id_p1", id_instr_p1, 32'd1000 + 32'(i));
      check("run_id_p2", id_instr_p2, 32'd2000 + 32'(i));
      check("run_valid", {31'd0, id_valid}, 32'd1);
    end

    // stall_len=2 at pc=16
    stall_req = 1'b1; stall_len = 2'd2; if_instr_p1 = 32'hBAD0_0000;
    #1;
    check("s2_pc", pc, 32'd16);
    check_ctl("s2_c1_ctl", 3'b001);
    check("s2_c1_active", {31'd0, stall_active}, 32'd0);
    step();
    stall_req = 1'b0;
    #1;
    check("s2_c2_cnt", {30'd0, stall_cnt}, 32'd1);
    check("s2_c2_active", {31'd0, stall_active}, 32'd1);
    check_ctl("s2_c2_ctl", 3'b001);
    check("s2_c2_pc", pc, 32'd16);
    step();
    if_instr_p1 = 32'd1002; if_instr_p2 = 32'd2002;
    #1;
    check("s2_c3_cnt", {30'd0, stall_cnt}, 32'd0);
    check("s2_c3_active", {31'd0, stall_active}, 32'd0);
    check_ctl("s2_c3_ctl", 3'b110);
    check("s2_hold_id", id_instr_p1, 32'd1001);
    step();
    check("s2_resume_pc", pc, 32'd24);
    check("s2_resume_id", id_instr_p1, 32'd1002);

    // stall_len=0 behaves as a single stall cycle
    stall_req = 1'b1; stall_len = 2'd0;
    #1;
    check_ctl("s0_c1_ctl", 3'b001);
    step();
    stall_req = 1'b0;
    #1;
    check("s0_active", {31'd0, stall_active}, 32'd0);
    check("s0_pc", pc, 32'd24);
    check_ctl("s0_c2_ctl", 3'b110);
    step();
    check("s0_resume_pc", pc, 32'd32);

    // stall_len=3 with a stall_req pulse during STALL that must be ignored
    stall_req = 1'b1; stall_len = 2'd3;
    step();
    stall_len = 2'd1;
    #1;
    check("s3_c2_cnt", {30'd0, stall_cnt}, 32'd2);
    check("s3_c2_active", {31'd0, stall_active}, 32'd1);
    step();
    stall_req = 1'b0;
    #1;
    check("s3_c3_cnt", {30'd0, stall_cnt}, 32'd1);
    check_ctl("s3_c3_ctl", 3'b001);
    step();
    #1;
    check("s3_c4_cnt", {30'd0, stall_cnt}, 32'd0);
    check("s3_c4_active", {31'd0, stall_active}, 32'd0);
    check_ctl("s3_c4_ctl", 3'b110);
    check("s3_c4_pc", pc, 32'd32);
    step();
    check("s3_resume_pc", pc, 32'd40);

    // Flush during the second cycle of a 3-cycle stall
    stall_req = 1'b1; stall_len = 2'd3;
    step();
    stall_req = 1'b0; flush_req = 1'b1; flush_target = 32'h100;
    #1;
    check("fl_pre_active", {31'd0, stall_active}, 32'd1);
    check_ctl("fl_ctl", 3'b111);
    step();
    flush_req = 1'b0;
    if_instr_p1 = 32'd3000; if_instr_p2 = 32'd4000;
    #1;
    check("fl_pc", pc, 32'h100);
    check("fl_id_p1", id_instr_p1, 32'd0);
    check("fl_id_p2", id_instr_p2, 32'd0);
    check("fl_valid", {31'd0, id_valid}, 32'd0);
    check("fl_active", {31'd0, stall_active}, 32'd0);
    check("fl_cnt", {30'd0, stall_cnt}, 32'd0);
    check_ctl("fl_next_ctl", 3'b110);
    step();
    check("fl_tgt_id", id_instr_p1, 32'd3000);
    check("fl_tgt_valid", {31'd0, id_valid}, 32'd1);
    check("fl_tgt_pc", pc, 32'h108);

    // Flush and stall together: flush wins, no stall cycles
    stall_req = 1'b1; stall_len = 2'd3; flush_req = 1'b1; flush_target = 32'hFFFF_FFF8;
    #1;
    check_ctl("fs_ctl", 3'b111);
    step();
    stall_req = 1'b0; flush_req = 1'b0;
    #1;
    check("fs_active", {31'd0, stall_active}, 32'd0);
    check("fs_cnt", {30'd0, stall_cnt}, 32'd0);
    check("wrap_pre_pc", pc, 32'hFFFF_FFF8);
    step();
    check("wrap_pc", pc, 32'd0);
    step();
    check("wrap_next_pc", pc, 32'd8);

    // Asynchronous reset in the middle of a stall
    stall_req = 1'b1; stall_len = 2'd3;
    step();
    stall_req = 1'b0;
    #1;
    check("mr_pre_active", {31'd0, stall_active}, 32'd1);
    rst = 1'b1;
    #1;
    check("mr_pc", pc, 32'd0);
    check("mr_active", {31'd0, stall_active}, 32'd0);
    check("mr_cnt", {30'd0, stall_cnt}, 32'd0);
    check("mr_valid", {31'd0, id_valid}, 32'd0);
    check("mr_id_p1", id_instr_p1, 32'd0);
    check_ctl("mr_ctl", 3'b001);
    step();
    rst = 1'b0;
    #1;
    check_ctl("mr_rel_ctl", 3'b110);
    step();
    check("mr_rel_pc", pc, 32'd8);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
